// File: rtl/sample_capture_buffer.sv
// Snapshot capture buffer: after an arm, skips SKIP_SAMPLES valid samples, stores BUFFER_DEPTH
// samples, then freezes the buffer for random reads until acq_done or abort.
module sample_capture_buffer #(
    parameter int unsigned SAMPLE_WIDTH = 4,
    parameter int unsigned BUFFER_DEPTH = 16368,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned SKIP_SAMPLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    input  logic                    acq_done,
    output logic                    acq_start,
    output logic                    buffer_full,
    output logic                    capture_busy,
    output logic                    overrun,
    output logic [ADDR_WIDTH:0]     sample_count
);

    typedef enum logic [1:0] {IDLE, SKIP, FILL, FULL} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUFFER_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(BUFFER_DEPTH);
    localparam logic [15:0]           SKIP_LAST = 16'(SKIP_SAMPLES - 1);

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [15:0]             skip_cnt;
    logic                    wr_en;

    // abort wins over a same-cycle write so a cancelled capture never touches memory
    always_comb begin
        wr_en = (state == FILL) && sample_valid && !abort;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            skip_cnt     <= '0;
            sample_count <= '0;
            overrun      <= 1'b0;
            acq_start    <= 1'b0;
            buffer_full  <= 1'b0;
            capture_busy <= 1'b0;
        end else begin
            acq_start <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                buffer_full  <= 1'b0;
                capture_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            overrun      <= 1'b0;
                            sample_count <= '0;
                            wr_ptr       <= '0;
                            skip_cnt     <= '0;
                            capture_busy <= 1'b1;
                            state        <= (SKIP_SAMPLES > 0) ? SKIP : FILL;
                        end
                    end
                    SKIP: begin
                        if (sample_valid) begin
                            skip_cnt <= skip_cnt + 1'b1;
                            if (skip_cnt == SKIP_LAST) begin
                                state <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (sample_valid) begin
                            wr_ptr       <= wr_ptr + 1'b1;
                            sample_count <= sample_count + 1'b1;
                            if (wr_ptr == LAST_ADDR) begin
                                state        <= FULL;
                                acq_start    <= 1'b1;
                                buffer_full  <= 1'b1;
                                capture_busy <= 1'b0;
                            end
                        end
                    end
                    FULL: begin
                        if (sample_valid) begin
                            overrun <= 1'b1;
                        end
                        if (acq_done) begin
                            state       <= IDLE;
                            buffer_full <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sample_capture_buffer.md
Name: sample_capture_buffer

Overview:
- Upstream stage of the B1I acquisition core: captures one code period of 4-bit signed IF samples (16368 samples = 1 ms) from the front-end into on-chip storage.
- When the snapshot is complete, it freezes the buffer and pulses acq_start.
- Serves random reads to the acquisition datapath until released by acq_done.
- Optional skip count discards samples after arm while front-end AGC settles.

Parameters:
- SAMPLE_WIDTH, 4, bits per signed sample.
- BUFFER_DEPTH, 16368, samples per snapshot (one B1I code period).
- ADDR_WIDTH, 14, address width; must satisfy 2^ADDR_WIDTH >= BUFFER_DEPTH.
- SKIP_SAMPLES, 0, valid samples discarded after arm before capture begins (0..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  request a new capture; honoured only in IDLE.
- abort  input  1  cancel capture/release buffer; return to IDLE.
- sample_in  input  SAMPLE_WIDTH  signed two's-complement IF sample.
- sample_valid  input  1  sample_in qualifier, at most one sample per cycle.
- rd_addr  input  ADDR_WIDTH  read address from acquisition datapath.
- rd_data  output  SAMPLE_WIDTH  registered read data.
- acq_done  input  1  acquisition finished; releases frozen buffer.
- acq_start  output  1  one-cycle pulse: snapshot complete, start acquisition.
- buffer_full  output  1  high while snapshot frozen and readable.
- capture_busy  output  1  high in SKIP or FILL.
- overrun  output  1  sticky: sample_valid seen while FULL.
- sample_count  output  ADDR_WIDTH+1  samples written in current snapshot.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - rd_data=0, acq_start=0, buffer_full=0, capture_busy=0, overrun=0, sample_count=0.
  - Skip counter and write pointer cleared.
  - Memory contents are not reset.
- States: IDLE, SKIP, FILL, FULL.
- IDLE:
  - On arm: go to SKIP if SKIP_SAMPLES>0, else FILL.
  - Arm also clears overrun, sample_count, write pointer and skip counter.
  - A sample_valid in the same cycle as arm is NOT captured or counted.
- SKIP:
  - Each sample_valid increments the skip counter.
  - When the SKIP_SAMPLES-th valid sample is discarded, go to FILL.
  - The next valid sample is written to address 0.
- FILL:
  - Each sample_valid writes sample_in to mem[wr_ptr], then increments wr_ptr and sample_count.
  - Gaps in sample_valid are allowed; no timeout.
  - The write at wr_ptr=BUFFER_DEPTH-1 goes to FULL on the next edge.
  - acq_start pulses high for exactly that first FULL cycle.
  - buffer_full rises in the same cycle as acq_start.
  - sample_count = BUFFER_DEPTH while in FULL.
- FULL:
  - Memory write-inhibited; incoming sample_valid sets overrun (sticky) and the sample is dropped.
  - On acq_done: go to IDLE; buffer_full falls the next cycle.
  - sample_count holds until the next arm.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in all states; 1-cycle latency.
  - rd_addr >= BUFFER_DEPTH returns 0.
  - Read and write to the same address in the same cycle returns the old data.
- abort:
  - Highest priority in every state: next state IDLE, buffer_full and capture_busy drop next cycle.
  - abort does not clear overrun or sample_count.
  - arm in the same cycle as abort is ignored.
- Ignored inputs:
  - arm in SKIP/FILL/FULL is ignored (no restart).
  - acq_done outside FULL is ignored.
  - acq_done and sample_valid in the same FULL cycle: overrun sets, then the block releases to IDLE.
- Outputs:
  - capture_busy = (state==SKIP || state==FILL), registered.
  - All outputs are registered; no combinational input-to-output paths.
- Timing: with continuous sample_valid and SKIP_SAMPLES=0, acq_start fires BUFFER_DEPTH+1 cycles after the arm cycle.

Test Plan:
- Reset then arm with continuous sample_valid, sample_in = addr mod 16 as signed, SKIP_SAMPLES=0 -> acq_start single pulse 16369 cycles after arm; sample_count=16368; reading addr 0,1,15,16367 returns 0,1,-1,-1 with 1-cycle latency.
- SKIP_SAMPLES=3, samples 7,6,5,4,3... -> mem[0]=4; capture_busy high from cycle after arm until FULL.
- sample_valid toggled every other cycle -> acq_start after 2*16368 cycles of valids; no overrun; data contiguous at addresses 0..16367.
- In FULL, drive 5 sample_valid then acq_done -> overrun=1; memory unchanged; buffer_full low the cycle after acq_done; next arm clears overrun.
- abort at sample_count=1000 with arm asserted simultaneously -> IDLE next cycle, sample_count stays 1000, no acq_start; later arm restarts at address 0.
- rst_n asserted mid-FILL -> all outputs 0 immediately (async); after release arm required to capture again; rd_addr=16368 returns 0.
